// File: rtl/tdm_mux8.sv
// tdm_mux8: time-division multiplexer. A frame of N_LANES lane values and an
// enable mask is accepted through a valid/ready handshake, then the enabled
// lanes are sent one per beat, in ascending order, over a single output
// channel. Each beat carries its lane index on out_sel, which drives the
// select input of the matching 1-to-N lane demultiplexer on the receive side.
// Frames whose mask is all zero are accepted but produce no beats. They are
// counted in a saturating drop counter.

module tdm_mux8 #(
    parameter  int N_LANES = 8,
    parameter  int W       = 1,
    localparam int SW      = $clog2(N_LANES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_LANES*W-1:0] in_data,
    input  logic [N_LANES-1:0]   in_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [SW-1:0]        out_sel,
    output logic                 out_last,
    output logic [15:0]          drop_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    // Index of the lowest set mask bit. This is a pure priority encoder, and
    // an all-zero mask yields 0.
    function automatic logic [SW-1:0] f_lowest(input logic [N_LANES-1:0] mask);
        logic [SW-1:0] idx;
        idx = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (mask[k]) idx = SW'(k);
        end
        return idx;
    endfunction

    // Mask bits strictly above lane idx. For the top lane, 2 << idx wraps to
    // zero in N_LANES bits, so the whole mask is cleared as intended.
    function automatic logic [N_LANES-1:0] f_above(input logic [N_LANES-1:0] mask,
                                                   input logic [SW-1:0]      idx);
        logic [N_LANES-1:0] w_upto;
        w_upto = (N_LANES'(2) << idx) - N_LANES'(1);
        return mask & ~w_upto;
    endfunction

    // Value of lane idx within a packed frame.
    function automatic logic [W-1:0] f_lane(input logic [N_LANES*W-1:0] frame,
                                            input logic [SW-1:0]        idx);
        return frame[int'(idx)*W +: W];
    endfunction

    state_t                 r_state;
    logic                   r_started;
    logic [N_LANES*W-1:0]   r_buf;
    logic [N_LANES-1:0]     r_mask;
    logic [SW-1:0]          r_sel;
    logic                   r_out_valid;
    logic [W-1:0]           r_out_data;
    logic [SW-1:0]          r_out_sel;
    logic                   r_out_last;
    logic [15:0]            r_drop_cnt;

    logic                   w_accept;
    logic                   w_consume;
    logic [SW-1:0]          w_in_sel;
    logic                   w_in_last;
    logic [SW-1:0]          w_next_sel;
    logic                   w_next_last;

    // in_ready is held low during reset and opens on the first edge after
    // release. A consumed last beat lets the next frame in without a bubble.
    assign in_ready = r_started &&
                      ((r_state == S_IDLE) || (r_out_valid && out_ready && r_out_last));

    // Handshake qualifiers and lane search for both the incoming frame and
    // the frame in flight.
    always_comb begin
        // NOTE: every signal gets a default value first so that no path can
        // leave one unassigned and infer a latch.
        w_accept    = 1'b0;
        w_consume   = 1'b0;
        w_in_sel    = '0;
        w_in_last   = 1'b0;
        w_next_sel  = '0;
        w_next_last = 1'b0;

        w_accept    = in_valid && in_ready;
        w_consume   = r_out_valid && out_ready;
        w_in_sel    = f_lowest(in_mask);
        w_in_last   = (f_above(in_mask, w_in_sel) == '0);
        w_next_sel  = f_lowest(f_above(r_mask, r_sel));
        w_next_last = (f_above(r_mask, w_next_sel) == '0);
    end

    // Control FSM with registered outputs. Frames are loaded on accept, sel
    // advances on each consumed beat, and all state holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the frame buffer is an ordinary register, not a memory, and is
        // cleared on reset like the rest of the state. Sequential state uses
        // non-blocking assignment only.
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_started   <= 1'b0;
            r_buf       <= '0;
            r_mask      <= '0;
            r_sel       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_last  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_accept) begin
                r_buf  <= in_data;
                r_mask <= in_mask;
                r_sel  <= w_in_sel;
                if (in_mask != '0) begin
                    r_state     <= S_SEND;
                    r_out_valid <= 1'b1;
                    r_out_sel   <= w_in_sel;
                    r_out_data  <= f_lane(in_data, w_in_sel);
                    r_out_last  <= w_in_last;
                end else begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    if (r_drop_cnt != DROP_MAX) begin
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                    end
                end
            end else if (w_consume) begin
                if (r_out_last) begin
                    // Frame finished with nothing waiting. The data, sel and
                    // last outputs keep their final values.
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end else begin
                    r_sel       <= w_next_sel;
                    r_out_sel   <= w_next_sel;
                    r_out_data  <= f_lane(r_buf, w_next_sel);
                    r_out_last  <= w_next_last;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_tdm_mux8.sv
// Testbench for tdm_mux8. A behavioural model turns each offered frame into
// the list of beats it must produce, and the DUT output is compared against
// that list beat by beat.

module tb_tdm_mux8;

    localparam int N  = 8;
    localparam int W  = 1;
    localparam int SW = 3;

    typedef struct {
        int sel;
        bit data;
        bit last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [N-1:0]  in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_sel;
    logic          out_last;
    logic [15:0]   drop_cnt;

    int    total = 0;
    int    bad   = 0;
    int    exp_drop = 0;
    beat_t exp_q[$];

    tdm_mux8 #(.N_LANES(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one beat per enabled lane in ascending order. The last beat is
    // the highest enabled lane. An empty mask yields no beats and one drop.
    function automatic void model_frame(input logic [N-1:0] d, input logic [N-1:0] m);
        int    hi;
        beat_t b;
        hi = -1;
        for (int k = 0; k < N; k++) if (m[k]) hi = k;
        if (hi < 0) begin
            if (exp_drop < 65535) exp_drop++;
        end
        for (int k = 0; k < N; k++) begin
            if (m[k]) begin
                b.sel  = k;
                b.data = d[k];
                b.last = (k == hi);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a frame and return after the edge that accepts it. Inputs are
    // then scrambled to show that the frame in flight does not depend on them.
    task automatic offer(input logic [N-1:0] d, input logic [N-1:0] m);
        int waited;
        in_data  = d;
        in_mask  = m;
        in_valid = 1'b1;
        waited   = 0;
        #1;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_data  = N'($urandom);
        in_mask  = N'($urandom);
    endtask

    // Send one frame and drain it. Each sampled beat is checked against the
    // model queue. Without backpressure, a cycle with no beat while beats are
    // still expected counts as a failure.
    task automatic run_frame(input logic [N-1:0] d, input logic [N-1:0] m, input bit bp);
        int cyc;
        out_ready = 1'b1;
        model_frame(d, m);
        offer(d, m);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (out_valid) begin
                total++;
                if (int'(out_sel) !== exp_q[0].sel || out_data !== exp_q[0].data ||
                    out_last !== exp_q[0].last) begin
                    bad++;
                    $display("FAIL beat: sel=%0d data=%0b last=%0b required sel=%0d data=%0b last=%0b",
                             out_sel, out_data, out_last, exp_q[0].sel, exp_q[0].data, exp_q[0].last);
                end
                total++;
                if (in_ready !== (out_ready && out_last)) begin
                    bad++;
                    $display("FAIL in_ready_during_send: in_ready=%0b required %0b",
                             in_ready, out_ready && out_last);
                end
                if (out_ready) void'(exp_q.pop_front());
            end else if (!bp) begin
                total++;
                bad++;
                $display("FAIL bubble: out_valid=0 required 1 (sel %0d pending)", exp_q[0].sel);
            end
            tick();
            cyc++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d beats missing required 0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL frame_end: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
        total++;
        if (drop_cnt !== 16'(exp_drop)) begin
            bad++;
            $display("FAIL drop_cnt: got %0d required %0d", drop_cnt, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        out_ready = 1'b1;
        exp_drop  = 0;
        #12;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || out_last !== 1'b0 ||
            drop_cnt !== 16'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: v=%0b d=%0b s=%0d l=%0b drop=%0d rdy=%0b required all 0",
                     out_valid, out_data, out_sel, out_last, drop_cnt, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_empty_mask();
        out_ready = 1'b1;
        in_data   = 8'hA5;
        in_mask   = 8'h00;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_frame(in_data, in_mask);
            tick();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL empty_mask_beat: out_valid=%0b in_ready=%0b required 0 1",
                         out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (drop_cnt !== 16'd2) begin
            bad++;
            $display("FAIL empty_mask_drops: drop_cnt=%0d required 2", drop_cnt);
        end
    endtask

    task automatic test_full_frame();
        run_frame(8'b1011_0010, 8'hFF, 1'b0);
    endtask

    task automatic test_sparse();
        run_frame(8'hFF, 8'b1010_0100, 1'b0);
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b1;
        offer(8'b0101_1101, 8'hFF);
        cyc = 0;
        while (!(out_valid && out_sel == 3'd3) && cyc < 20) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 1'b1 ||
                out_last !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: v=%0b s=%0d d=%0b l=%0b rdy=%0b required 1 3 1 0 0",
                         out_valid, out_sel, out_data, out_last, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_sel !== 3'd4 || out_data !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume: v=%0b s=%0d d=%0b required 1 4 1", out_valid, out_sel, out_data);
        end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_drain: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b1;
        offer(8'b1011_0010, 8'hFF);
        cyc = 0;
        while (!(out_valid && out_last) && cyc < 20) begin
            tick();
            cyc++;
        end
        in_data  = 8'h01;
        in_mask  = 8'h01;
        in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_sel !== 3'd7) begin
            bad++;
            $display("FAIL b2b_ready_on_last: in_ready=%0b sel=%0d required 1 7", in_ready, out_sel);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 1'b1 || out_last !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_frame: v=%0b s=%0d d=%0b l=%0b required 1 0 1 1",
                     out_valid, out_sel, out_data, out_last);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        out_ready = 1'b1;
        offer(8'hFF, 8'hFF);
        cyc = 0;
        while (!(out_valid && out_sel == 3'd4) && cyc < 20) begin
            tick();
            cyc++;
        end
        #2;
        rst_n = 1'b0;
        exp_drop = 0;
        #1;
        total++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd0 || out_sel !== '0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_frame: v=%0b drop=%0d s=%0d rdy=%0b required 0 0 0 0",
                     out_valid, drop_cnt, out_sel, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
        end
        run_frame(8'b0110_0000, 8'b0011_0000, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] d;
        logic [N-1:0] m;
        for (int i = 0; i < 40; i++) begin
            d = N'($urandom);
            m = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            run_frame(d, m, 1'($urandom_range(0, 1)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    initial begin
        test_reset();
        test_empty_mask();
        test_full_frame();
        test_sparse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_mux8.md
Name: tdm_mux8

Overview:
- Time-division multiplexer that sends a frame of parallel lanes out over one shared output channel.
- Accepts a frame of N_LANES lane values plus an enable mask through a valid/ready handshake.
- Sends enabled lanes one per output beat, in ascending lane order, tagged with the lane index.
- Sits on the transmit side, opposite the 1-to-8 lane demultiplexer; out_sel drives that demux's select input.

Parameters:
- N_LANES, 8, number of lanes per frame; must be a power of two, 2 to 16.
- W, 1, width of each lane value in bits.
- SW, $clog2(N_LANES), width of the lane index (derived, do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  frame offered.
- in_ready  output  1  frame accepted when in_valid && in_ready.
- in_data  input  N_LANES*W  lane k occupies bits [k*W +: W].
- in_mask  input  N_LANES  bit k=1 means lane k is sent.
- out_valid  output  1  beat available.
- out_ready  input  1  beat consumed when out_valid && out_ready.
- out_data  output  W  value of the current lane.
- out_sel  output  SW  index of the current lane.
- out_last  output  1  current beat is the highest enabled lane of the frame.
- drop_cnt  output  16  count of accepted frames whose mask was all zero.

Behaviour:
- Reset (asynchronous, rst_n=0), all values immediate:
  - state=IDLE; frame buffer=0; mask register=0; sel=0.
  - out_valid=0, out_data=0, out_sel=0, out_last=0, drop_cnt=0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first clk edge after release.
- States: IDLE, SEND.
- in_ready rule:
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - The second term allows back-to-back frames with zero bubble.
- Frame accept, when in_valid && in_ready:
  - Register in_data and in_mask.
  - Set sel to the lowest set bit of in_mask.
  - If in_mask != 0: go to SEND; out_valid=1 on the next cycle. Latency from accept to first beat is 1 clk.
  - If in_mask == 0: go to (or stay in) IDLE; drop_cnt increments and saturates at 16'hFFFF; no beat is emitted.
- SEND outputs:
  - out_valid=1.
  - out_sel=sel.
  - out_data=buffer[sel*W +: W].
  - out_last=1 iff no mask bit above sel is set.
- Stall: while out_ready=0, all outputs and internal state hold and in_ready=0. Data must not change under backpressure.
- Beat consumed, not last: sel advances to the next set mask bit above sel. Disabled lanes cost no cycles.
- Beat consumed, last:
  - If in_valid is also high: the new frame is loaded in the same cycle and the rules above apply. An all-zero mask on that frame goes to IDLE and increments drop_cnt.
  - Otherwise: go to IDLE with out_valid=0 on the next cycle. out_data, out_sel and out_last hold their last values (don't-care).
- Throughput: one beat per clk when out_ready is held high; a full-mask frame takes N_LANES cycles.
- Input stability: in_data and in_mask are sampled only at accept; later changes have no effect on the frame in flight.
- Reset mid-frame: the frame is discarded, outputs return to reset values immediately, and no partial beat is emitted after release.
- Lane search: a priority encoder over (mask & ~((2 << sel) - 1)); no loops spanning multiple cycles.

Test Plan:
- Full frame: in_data=8'b1011_0010, in_mask=8'hFF, out_ready=1 -> 8 beats, out_sel 0..7, out_data 0,1,0,0,1,1,0,1; out_last only at sel=7; in_ready=1 in that same cycle.
- Sparse mask: in_mask=8'b1010_0100, in_data=8'hFF -> 3 consecutive beats with out_sel 2,5,7, out_data=1 each; out_last at sel=7; no idle cycles between beats.
- Backpressure: full frame with out_ready=0 for 3 clks at sel=3 -> out_sel=3, out_data and out_valid held steady, in_ready=0; beat sel=4 follows 1 clk after out_ready rises.
- Back-to-back: second frame (in_mask=8'h01, in_data=8'h01) held valid during the last beat of the first frame -> accepted on the same edge; next cycle out_sel=0, out_data=1, out_last=1.
- Empty mask: in_mask=8'h00 accepted twice -> no out_valid pulse; drop_cnt=2; in_ready stays 1.
- Reset mid-frame: assert rst_n=0 at sel=4 -> out_valid=0 and drop_cnt=0 immediately; after release in_ready=1 and the next frame starts at its lowest enabled lane.
